cnn_conv_bias_relu: RTL and testbench
=====================================

# cnn_conv_bias_relu

Per-channel bias-add and ReLU stage placed directly downstream of the 3x3 convolution layer's output alignment stage. Receives the channel-interleaved output stream (all `CHANNEL_NUM_OUT` channels of one output pixel on consecutive valid beats). Adds a preloaded per-channel bias with saturation, optionally applies ReLU, and forwards the stream with fixed latency. Also tracks frame boundaries and flags pixels that arrive before the bias table is loaded.

## Interface
- `DATA_WIDTH`, 16: signed two's-complement fixed-point sample width; bias uses the same format.
- `CHANNEL_NUM_OUT`, 128: channels per output pixel, which is also the bias table depth.
- `OUT_WIDTH`, 128: output feature-map width in pixels.
- `OUT_HEIGHT`, 128: output feature-map height in pixels.
- `RELU_EN`, 1: 1 applies ReLU; 0 passes the signed saturated sum.
- Derived: `CH_CNT_WIDTH` = clog2(`CHANNEL_NUM_OUT`); `PXL_CNT_WIDTH` = clog2(`OUT_WIDTH`*`OUT_HEIGHT`).

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `valid_bias_in` input 1: bias write strobe.
- `bias_in` input `DATA_WIDTH`: bias value; entries load in channel order 0..N-1.
- `valid_in` input 1: pixel beat valid.
- `pxl_in` input `DATA_WIDTH`: convolution output sample.
- `pxl_out` output `DATA_WIDTH`: biased and activated sample.
- `valid_out` output 1: `pxl_out` is valid.
- `bias_ready` output 1: bias table is fully loaded and the block is in RUN.
- `frame_done` output 1: one-cycle pulse coincident with the last output beat of a frame.
- `drop_err` output 1: sticky flag; set when a pixel beat is dropped.

## Operation
- State machine:
  - LOAD (reset state): each `valid_bias_in` writes `bias_in` to `bias_mem[wr_ptr]` and increments `wr_ptr`. The write at `wr_ptr == CHANNEL_NUM_OUT-1` moves the state to RUN.
  - RUN: `valid_bias_in` is ignored. The table is held until `reset`; there is no return to LOAD.
- `valid_in` in LOAD: the beat is dropped, no output is produced, and `drop_err` is set.
- `valid_in` in RUN:
  - Stage 1 registers `pxl_in` and `bias_mem[ch_cnt]`.
  - `ch_cnt` increments and wraps from `CHANNEL_NUM_OUT-1` to 0.
  - On each wrap, `pxl_cnt` increments; it wraps from `OUT_WIDTH*OUT_HEIGHT-1` to 0.
- Stage 2 arithmetic: sum = sign-extended `pxl` + sign-extended `bias`, computed at `DATA_WIDTH+1` bits.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1].
  - If `RELU_EN` and the result is negative, output 0.
- `frame_done` is asserted with the output beat whose input had `ch_cnt == CHANNEL_NUM_OUT-1` and `pxl_cnt == last`. It is carried down the pipeline as a tag.
- A `valid_bias_in` arriving on the same cycle as the final LOAD write cannot occur, because the writes are sequential. The first RUN-cycle `valid_in` is processed: the state change takes effect on the clock edge after the last bias write.
- Gaps in `valid_in` are allowed. Counters and pipeline tags advance only on valid beats, and the pipeline advances every cycle; there is no backpressure.
- `bias_mem` may be inferred as distributed RAM (one synchronous write, one read). It is not reset; contents are only meaningful after a full load.

## Timing
- Reset (asynchronous assert, synchronous deassert at the system level) clears the following:
  - `pxl_out` = 0, `valid_out` = 0, `bias_ready` = 0, `frame_done` = 0, `drop_err` = 0.
  - State = LOAD; `wr_ptr`, `ch_cnt`, `pxl_cnt` = 0; pipeline valids and tags = 0.
- Latency: a valid input beat at edge k produces `valid_out`/`pxl_out` at edge k+2. Throughput is 1 beat per cycle.
- `bias_ready` rises on the edge that performs the last bias write. It stays high until reset.
- Reset asserted mid-frame or mid-load: everything in the reset list clears immediately and in-flight beats are discarded. After reset, the full bias table must be reloaded.
- `frame_done` is exactly 1 cycle wide. Back-to-back frames with no gap are supported.

## Test plan
- Load and pass (`CHANNEL_NUM_OUT`=4, 2x2 frame): biases {10,-5,0,3}, pixels 100 on all channels -> out {110,95,100,103} repeating, 2-cycle latency, `bias_ready` high after the 4th write.
- ReLU and saturation, `DATA_WIDTH`=16:
  - pxl -200 + bias 10 -> 0 (`RELU_EN`=1); -190 (`RELU_EN`=0).
  - pxl 32760 + bias 100 -> 32767.
  - pxl -32768 + bias -1 with `RELU_EN`=0 -> -32768.
- Frame boundary: 2x2x4 frame streamed twice with random valid gaps -> `frame_done` pulses exactly on the 16th and 32nd output beats; channel alignment is preserved across the gaps.
- Early pixels: 3 `valid_in` beats before the bias load completes -> no `valid_out`, `drop_err`=1. After load, output is correct with `ch_cnt` starting at 0.
- Bias writes in RUN: extra `valid_bias_in` beats of 999 -> outputs unchanged.
- Reset mid-frame: assert `reset` after 6 beats -> all outputs 0 within the same cycle. Reload biases {1,2,3,4}, then stream one frame -> correct sums and a single `frame_done` at beat 16.

Source files
------------

// File: rtl/cnn_conv_bias_relu.sv
// Per-channel bias add with saturation and optional ReLU on a channel-interleaved
// conv output stream; two register stages, frame tagging and early-beat detection.
module cnn_conv_bias_relu #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned CHANNEL_NUM_OUT = 128,
    parameter int unsigned OUT_WIDTH       = 128,
    parameter int unsigned OUT_HEIGHT      = 128,
    parameter bit          RELU_EN         = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_bias_in,
    input  logic [DATA_WIDTH-1:0] bias_in,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  bias_ready,
    output logic                  frame_done,
    output logic                  drop_err
);

    localparam int unsigned CH_CNT_WIDTH  = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
    localparam int unsigned PXL_NUM       = OUT_WIDTH * OUT_HEIGHT;
    localparam int unsigned PXL_CNT_WIDTH = (PXL_NUM > 1) ? $clog2(PXL_NUM) : 1;
    localparam int unsigned SUM_WIDTH     = DATA_WIDTH + 1;

    localparam logic [CH_CNT_WIDTH-1:0]  CH_LAST  = CH_CNT_WIDTH'(CHANNEL_NUM_OUT - 1);
    localparam logic [PXL_CNT_WIDTH-1:0] PXL_LAST = PXL_CNT_WIDTH'(PXL_NUM - 1);
    localparam logic [DATA_WIDTH-1:0]    SAT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]    SAT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [CH_CNT_WIDTH-1:0]  wr_ptr;
    logic [CH_CNT_WIDTH-1:0]  ch_cnt;
    logic [PXL_CNT_WIDTH-1:0] pxl_cnt;
    logic [DATA_WIDTH-1:0]    bias_mem [CHANNEL_NUM_OUT];

    logic bias_we_c;
    logic beat_c;
    logic drop_c;
    logic last_wr_c;

    logic                  s1_valid;
    logic                  s1_last;
    logic [DATA_WIDTH-1:0] s1_pxl;
    logic [DATA_WIDTH-1:0] s1_bias;

    logic [SUM_WIDTH-1:0]  sum_c;
    logic [DATA_WIDTH-1:0] act_c;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle strobes
    always_comb begin
        state_nxt = state;
        bias_we_c = 1'b0;
        beat_c    = 1'b0;
        drop_c    = 1'b0;
        last_wr_c = 1'b0;
        case (state)
            ST_LOAD: begin
                bias_we_c = valid_bias_in;
                drop_c    = valid_in;
                last_wr_c = valid_bias_in && (wr_ptr == CH_LAST);
                if (last_wr_c) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                beat_c = valid_in;
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    // Bias table: not reset, only meaningful after a complete load
    always_ff @(posedge clk) begin
        if (bias_we_c) begin
            bias_mem[wr_ptr] <= bias_in;
        end
    end

    // Load pointer, stream counters and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            ch_cnt     <= '0;
            pxl_cnt    <= '0;
            bias_ready <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            if (bias_we_c) begin
                wr_ptr <= wr_ptr + CH_CNT_WIDTH'(1);
            end
            if (last_wr_c) begin
                bias_ready <= 1'b1;
            end
            if (drop_c) begin
                drop_err <= 1'b1;
            end
            if (beat_c) begin
                if (ch_cnt == CH_LAST) begin
                    ch_cnt  <= '0;
                    pxl_cnt <= (pxl_cnt == PXL_LAST) ? '0 : pxl_cnt + PXL_CNT_WIDTH'(1);
                end else begin
                    ch_cnt <= ch_cnt + CH_CNT_WIDTH'(1);
                end
            end
        end
    end

    // Stage 1: capture sample with its channel bias and end-of-frame tag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_pxl   <= '0;
            s1_bias  <= '0;
        end else begin
            s1_valid <= beat_c;
            s1_last  <= beat_c && (ch_cnt == CH_LAST) && (pxl_cnt == PXL_LAST);
            if (beat_c) begin
                s1_pxl  <= pxl_in;
                s1_bias <= bias_mem[ch_cnt];
            end
        end
    end

    // One extra bit of headroom makes overflow visible as a sign-bit disagreement
    assign sum_c = {s1_pxl[DATA_WIDTH-1], s1_pxl} + {s1_bias[DATA_WIDTH-1], s1_bias};

    always_comb begin
        act_c = sum_c[DATA_WIDTH-1:0];
        if (sum_c[SUM_WIDTH-1] != sum_c[SUM_WIDTH-2]) begin
            act_c = sum_c[SUM_WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
        if (RELU_EN && act_c[DATA_WIDTH-1]) begin
            act_c = '0;
        end
    end

    // Stage 2: registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= s1_valid;
            frame_done <= s1_last;
            if (s1_valid) begin
                pxl_out <= act_c;
            end
        end
    end

endmodule

// File: tb/tb_cnn_conv_bias_relu.sv
// Scoreboard bench for cnn_conv_bias_relu: 4 channels, 2x2 frame, one ReLU and
// one pass-through instance driven by the same stream.
module tb_cnn_conv_bias_relu;

    localparam int unsigned DW = 16;

    logic          clk;
    logic          reset;
    logic          valid_bias_in;
    logic [DW-1:0] bias_in;
    logic          valid_in;
    logic [DW-1:0] pxl_in;

    logic [DW-1:0] pxl_out1, pxl_out0;
    logic          valid_out1, valid_out0;
    logic          bias_ready1, bias_ready0;
    logic          frame_done1, frame_done0;
    logic          drop_err1, drop_err0;

    cnn_conv_bias_relu #(
        .DATA_WIDTH(DW), .CHANNEL_NUM_OUT(4), .OUT_WIDTH(2), .OUT_HEIGHT(2), .RELU_EN(1'b1)
    ) u_dut_relu (
        .clk(clk), .reset(reset),
        .valid_bias_in(valid_bias_in), .bias_in(bias_in),
        .valid_in(valid_in), .pxl_in(pxl_in),
        .pxl_out(pxl_out1), .valid_out(valid_out1), .bias_ready(bias_ready1),
        .frame_done(frame_done1), .drop_err(drop_err1)
    );

    cnn_conv_bias_relu #(
        .DATA_WIDTH(DW), .CHANNEL_NUM_OUT(4), .OUT_WIDTH(2), .OUT_HEIGHT(2), .RELU_EN(1'b0)
    ) u_dut_lin (
        .clk(clk), .reset(reset),
        .valid_bias_in(valid_bias_in), .bias_in(bias_in),
        .valid_in(valid_in), .pxl_in(pxl_in),
        .pxl_out(pxl_out0), .valid_out(valid_out0), .bias_ready(bias_ready0),
        .frame_done(frame_done0), .drop_err(drop_err0)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          fd;
        int            cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    bit m_loaded;
    int m_wr;
    int m_ch;
    int m_pxl;
    int m_bias[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] sat(input int s, input bit relu);
        int r;
        r = s;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return DW'(r);
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_out1) begin
                if (q1.size() == 0) begin
                    chk("relu unexpected beat", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("relu data", $signed(pxl_out1), $signed(e.data));
                    chk("relu frame_done", int'(frame_done1), int'(e.fd));
                    chk("relu latency", cyc, e.cyc);
                end
            end else if (frame_done1) begin
                chk("relu stray frame_done", 1, 0);
            end
            if (valid_out0) begin
                if (q0.size() == 0) begin
                    chk("lin unexpected beat", 1, 0);
                end else begin
                    e = q0.pop_front();
                    chk("lin data", $signed(pxl_out0), $signed(e.data));
                    chk("lin frame_done", int'(frame_done0), int'(e.fd));
                    chk("lin latency", cyc, e.cyc);
                end
            end else if (frame_done0) begin
                chk("lin stray frame_done", 1, 0);
            end
        end
    endtask

    // One pixel beat; expected values either hand-given or taken from the model table
    task automatic beat(input int p, input bit hand, input int e1, input int e0,
                        input bit vb, input int b);
        exp_t e;
        @(posedge clk);
        #1;
        valid_in      = 1'b1;
        pxl_in        = DW'(p);
        valid_bias_in = vb;
        bias_in       = DW'(b);
        if (m_loaded) begin
            e.fd  = (m_ch == 3) && (m_pxl == 3);
            e.cyc = cyc + 2;
            e.data = hand ? DW'(e1) : sat(p + m_bias[m_ch], 1'b1);
            q1.push_back(e);
            e.data = hand ? DW'(e0) : sat(p + m_bias[m_ch], 1'b0);
            q0.push_back(e);
            if (m_ch == 3) begin
                m_ch  = 0;
                m_pxl = (m_pxl == 3) ? 0 : m_pxl + 1;
            end else begin
                m_ch++;
            end
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        valid_in      = 1'b0;
        valid_bias_in = 1'b0;
    endtask

    task automatic bw(input int b);
        @(posedge clk);
        #1;
        valid_in      = 1'b0;
        valid_bias_in = 1'b1;
        bias_in       = DW'(b);
        if (!m_loaded) begin
            m_bias[m_wr] = b;
            m_wr++;
            if (m_wr == 4) m_loaded = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        valid_in      = 1'b0;
        valid_bias_in = 1'b0;
        reset         = 1'b0;
        q1.delete();
        q0.delete();
        m_loaded = 1'b0;
        m_wr = 0;
        m_ch = 0;
        m_pxl = 0;
        #1;
        chk("rst pxl_out", int'(pxl_out1), 0);
        chk("rst valid_out", int'(valid_out1), 0);
        chk("rst bias_ready", int'(bias_ready1), 0);
        chk("rst frame_done", int'(frame_done1), 0);
        chk("rst drop_err", int'(drop_err1), 0);
        chk("rst lin pxl_out", int'(pxl_out0), 0);
        chk("rst lin valid_out", int'(valid_out0), 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    task automatic drain();
        repeat (4) idle();
        chk("relu queue drained", q1.size(), 0);
        chk("lin queue drained", q0.size(), 0);
    endtask

    int pass_tbl[4] = '{110, 95, 100, 103};

    initial begin
        reset         = 1'b0;
        valid_bias_in = 1'b0;
        bias_in       = '0;
        valid_in      = 1'b0;
        pxl_in        = '0;
        fork
            monitor();
        join_none

        do_reset();

        // Early beats before the table is loaded are dropped
        repeat (3) beat(77, 1'b0, 0, 0, 1'b0, 0);
        idle();
        chk("early drop_err", int'(drop_err1), 1);
        chk("early drop_err lin", int'(drop_err0), 1);

        bw(10); bw(-5); bw(0); bw(3);
        chk("bias_ready before last write", int'(bias_ready1), 0);
        idle();
        chk("bias_ready after load", int'(bias_ready1), 1);
        chk("bias_ready after load lin", int'(bias_ready0), 1);

        // Two frames of 100 with random gaps; 999 bias writes in the second frame
        for (int i = 0; i < 32; i++) begin
            beat(100, 1'b1, pass_tbl[i % 4], pass_tbl[i % 4], i >= 16, 999);
            repeat ($urandom_range(0, 2)) idle();
        end
        drain();
        chk("bias_ready held", int'(bias_ready1), 1);

        // Saturation and ReLU corners
        do_reset();
        bw(10); bw(100); bw(-1); bw(0);
        idle();
        beat(-200,   1'b1, 0,     -190,   1'b0, 0);
        beat(32760,  1'b1, 32767, 32767,  1'b0, 0);
        beat(-32768, 1'b1, 0,     -32768, 1'b0, 0);
        beat(-5,     1'b1, 0,     -5,     1'b0, 0);
        drain();

        // Reset mid-frame discards in-flight beats and the table
        for (int i = 0; i < 6; i++) beat(50 + i, 1'b0, 0, 0, 1'b0, 0);
        do_reset();
        bw(1); bw(2); bw(3); bw(4);
        idle();
        for (int i = 0; i < 16; i++) begin
            beat(i * 37 - 250, 1'b0, 0, 0, 1'b0, 0);
            if (i % 5 == 2) idle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
